// File: rtl/pwm_capture.sv
// Servo-PWM pulse decoder: measures high time and rise-to-rise period
// of a synchronized PWM line, with timeout and range flags.
module pwm_capture #(
  parameter int CNT_W   = 20,
  parameter int TIMEOUT = 1000000,
  parameter int MIN_W   = 50000,
  parameter int MAX_W   = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             range_ok,
  output logic             timeout,
  output logic             leden,
  output logic             led
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    WAIT_RISE,
    HIGH,
    LOW
  } state_e;

  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             rok_q, rok_d;
  logic             valid_q, valid_d;
  logic             tout_q, tout_d;
  logic             led_q, led_d;
  logic             leden_q;
  logic             s1_q, pwm_s_q, pwm_d_q;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             in_range;

  assign cnt_inc  = cnt_q + ONE;
  assign in_range = (wid_q >= MIN_C) && (wid_q <= MAX_C);

  // Edges are registered so both rise and fall see the same 3-cycle lag.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= pwm_in;
      pwm_s_q <= s1_q;
      pwm_d_q <= pwm_s_q;
      rise_q  <= pwm_s_q & ~pwm_d_q;
      fall_q  <= ~pwm_s_q & pwm_d_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wid_d    = wid_q;
    width_d  = width_q;
    period_d = period_q;
    rok_d    = rok_q;
    valid_d  = 1'b0;
    tout_d   = 1'b0;
    led_d    = led_q;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!pwm_s_q) state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise_q) begin
            cnt_d   = ONE;
            state_d = HIGH;
          end
        end
        HIGH: begin
          if (fall_q) begin
            wid_d   = cnt_q;
            cnt_d   = cnt_inc;
            state_d = LOW;
          end else if (cnt_q == TO_C) begin
            tout_d  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_LOW;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise_q) begin
            period_d = cnt_q;
            width_d  = wid_q;
            rok_d    = in_range;
            valid_d  = 1'b1;
            led_d    = ~led_q;
            cnt_d    = ONE;
            state_d  = HIGH;
          end else if (cnt_q == TO_C) begin
            tout_d  = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_LOW;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wid_q    <= '0;
      width_q  <= '0;
      period_q <= '0;
      rok_q    <= 1'b0;
      valid_q  <= 1'b0;
      tout_q   <= 1'b0;
      led_q    <= 1'b0;
      leden_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wid_q    <= wid_d;
      width_q  <= width_d;
      period_q <= period_d;
      rok_q    <= rok_d;
      valid_q  <= valid_d;
      tout_q   <= tout_d;
      led_q    <= led_d;
      leden_q  <= enable;
    end
  end

  assign width    = width_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign range_ok = rok_q;
  assign timeout  = tout_q;
  assign leden    = leden_q;
  assign led      = led_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus pushes expected events,
// a negedge monitor pops and compares on valid/timeout.
module tb_pwm_capture;
  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          pwm_in;
  logic [CW-1:0] width;
  logic [CW-1:0] period;
  logic          valid;
  logic          range_ok;
  logic          timeout;
  logic          leden;
  logic          led;

  typedef struct {
    bit tout;
    int w;
    int p;
    bit rok;
    int t;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_n = 0;
  int   last_m = 0;
  bit   led_m = 1'b0;

  pwm_capture #(
    .CNT_W(CW),
    .TIMEOUT(400),
    .MIN_W(50),
    .MAX_W(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .pwm_in(pwm_in),
    .width(width),
    .period(period),
    .valid(valid),
    .range_ok(range_ok),
    .timeout(timeout),
    .leden(leden),
    .led(led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit rok(input int w);
    return (w >= 50) && (w <= 100);
  endfunction

  task automatic push(input bit to, input int w, input int p,
                      input int dt);
    exp_t e;
    e.tout = to;
    e.w    = w;
    e.p    = p;
    e.rok  = rok(w);
    e.t    = cyc + dt;
    sbq.push_back(e);
  endtask

  // A rise closes the previous full cycle: valid 4 cycles later.
  task automatic pulse(input int n, input int m, input bit closes);
    pwm_in = 1'b1;
    if (closes) push(1'b0, last_n, last_n + last_m, 4);
    tick(n);
    pwm_in = 1'b0;
    tick(m);
    last_n = n;
    last_m = m;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_width"}, int'(width), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_range_ok"}, int'(range_ok), 0);
    chk({tag, "_timeout"}, int'(timeout), 0);
    chk({tag, "_leden"}, int'(leden), 0);
    chk({tag, "_led"}, int'(led), 0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        led_m = 1'b0;
      end else if (valid || timeout) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: valid=%0d timeout=%0d cycle %0d",
                   valid, timeout, cyc);
        end else begin
          e = sbq.pop_front();
          chk("event_kind", int'(timeout), int'(e.tout));
          chk("event_cycle", cyc, e.t);
          chk("width", int'(width), e.w);
          chk("period", int'(period), e.p);
          if (!e.tout) begin
            led_m = ~led_m;
            chk("range_ok", int'(range_ok), int'(e.rok));
            chk("led", int'(led), int'(led_m));
          end
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    pwm_in = 1'b0;
    tick(3);
    reset = 1'b0;
    chk_reset_vals("rst");
    enable = 1'b1;
    chk("leden_lag_on", int'(leden), 0);
    tick(1);
    chk("leden_on", int'(leden), 1);
    tick(5);

    // in-range stream, then out-of-range and boundary widths
    pulse(75, 125, 1'b0);
    pulse(75, 125, 1'b1);
    pulse(75, 125, 1'b1);
    pulse(30, 170, 1'b1);
    pulse(30, 170, 1'b1);
    pulse(101, 99, 1'b1);
    pulse(100, 100, 1'b1);

    // stuck high: closes 100/200, then timeout 400 counts after the rise
    pwm_in = 1'b1;
    push(1'b0, 100, 200, 4);
    push(1'b1, 100, 200, 404);
    tick(500);
    pwm_in = 1'b0;
    tick(50);
    pulse(60, 140, 1'b0);
    pulse(80, 120, 1'b1);

    // enable rises while the line is already high
    enable = 1'b0;
    tick(5);
    pwm_in = 1'b1;
    tick(20);
    enable = 1'b1;
    tick(30);
    pwm_in = 1'b0;
    tick(100);
    pulse(55, 145, 1'b0);
    pulse(90, 110, 1'b1);

    // enable dropped mid-HIGH for 10 cycles
    pwm_in = 1'b1;
    push(1'b0, 90, 200, 4);
    tick(20);
    enable = 1'b0;
    chk("leden_lag_off", int'(leden), 1);
    tick(1);
    chk("leden_off", int'(leden), 0);
    tick(9);
    enable = 1'b1;
    chk("leden_lag_reon", int'(leden), 0);
    tick(1);
    chk("leden_reon", int'(leden), 1);
    tick(40);
    pwm_in = 1'b0;
    tick(120);
    pulse(70, 130, 1'b0);
    pulse(65, 135, 1'b1);

    // reset mid-LOW, then a one-cycle glitch
    pwm_in = 1'b1;
    push(1'b0, 65, 200, 4);
    tick(50);
    pwm_in = 1'b0;
    tick(60);
    reset = 1'b1;
    tick(1);
    chk_reset_vals("midrst");
    reset = 1'b0;
    tick(20);
    pulse(1, 100, 1'b0);
    pulse(60, 140, 1'b1);
    tick(20);

    chk("queue_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
